// File: rtl/nes_line_doubler.sv
// One-line PPU scan doubler: ping-pong 256-pixel banks, each line replayed twice with pixels doubled.
// Optional LINE_DOUBLER_BLEND_EN: odd output columns carry the per-channel average of neighbours.
module nes_line_doubler #(
  parameter int PIX_W             = 15,
  parameter int FIRST_LINE_SYNC_H = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic [8:0]       count_h,
  input  logic [8:0]       count_v,
  input  logic [9:0]       rd_x,
  output logic [PIX_W-1:0] pixel_out,
  output logic             frame_sync,
  output logic             line_sync
);

  localparam logic [8:0] LP_SYNC_H = FIRST_LINE_SYNC_H[8:0];

  logic [PIX_W-1:0] r_bank0 [0:255];
  logic [PIX_W-1:0] r_bank1 [0:255];

  logic [8:0]       r_count_h_prev;
  logic [8:0]       r_count_v_prev;
  logic             r_rd_bank;
  logic             r_line_sync;
  logic             r_frame_sync;
  logic [PIX_W-1:0] r_pixel_out;

  logic             w_new_dot;
  logic             w_visible;
  logic             w_wr_en;
  logic             w_line_evt;
  logic             w_frame_evt;
  logic [7:0]       w_rd_addr;
  logic [PIX_W-1:0] w_rd_p0;
  logic [PIX_W-1:0] w_pix_nxt;

`ifdef LINE_DOUBLER_BLEND_EN
  logic [7:0]       w_rd_addr_nx;
  logic [PIX_W-1:0] w_rd_p1;

  // Per-channel (a+b)>>1 over 5-bit fields; the 6-bit sum is truncated after the shift.
  function automatic logic [PIX_W-1:0] f_blend(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    logic [PIX_W-1:0] res;
    logic [5:0]       sum;
    res = '0;
    for (int c = 0; c < PIX_W / 5; c++) begin
      sum = {1'b0, a[c*5 +: 5]} + {1'b0, b[c*5 +: 5]};
      res[c*5 +: 5] = sum[5:1];
    end
    return res;
  endfunction
`else
  logic             w_unused_rd_x0;
  assign w_unused_rd_x0 = rd_x[0];
`endif

  assign w_new_dot   = (count_h != r_count_h_prev);
  assign w_visible   = (count_v < 9'd240);
  assign w_wr_en     = !reset && w_new_dot && (count_h < 9'd256) && w_visible;
  assign w_line_evt  = w_new_dot && (count_h == LP_SYNC_H) && w_visible;
  assign w_frame_evt = (r_count_v_prev == 9'd511) && (count_v == 9'd0);
  assign w_rd_addr   = rd_x[8:1];

  assign w_rd_p0 = r_rd_bank ? r_bank1[w_rd_addr] : r_bank0[w_rd_addr];

`ifdef LINE_DOUBLER_BLEND_EN
  // The last pixel of the line blends with itself.
  assign w_rd_addr_nx = (w_rd_addr == 8'hFF) ? w_rd_addr : (w_rd_addr + 8'd1);
  assign w_rd_p1      = r_rd_bank ? r_bank1[w_rd_addr_nx] : r_bank0[w_rd_addr_nx];
`endif

  // Select the next output pixel; columns beyond the visible 512 are black.
  always_comb begin
    w_pix_nxt = '0;
    if (rd_x[9] == 1'b0) begin
`ifdef LINE_DOUBLER_BLEND_EN
      if (rd_x[0]) begin
        w_pix_nxt = f_blend(w_rd_p0, w_rd_p1);
      end else begin
        w_pix_nxt = w_rd_p0;
      end
`else
      w_pix_nxt = w_rd_p0;
`endif
    end else begin
      w_pix_nxt = '0;
    end
  end

  // Line RAM write port: the even/odd PPU line picks the bank; RAM is never cleared.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (count_v[0]) begin
        r_bank1[count_h[7:0]] <= pixel_in;
      end else begin
        r_bank0[count_h[7:0]] <= pixel_in;
      end
    end
  end

  // Count history, sync pulses, read-bank tracking and the registered output pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count_h_prev <= 9'd0;
      r_count_v_prev <= 9'd0;
      r_line_sync    <= 1'b0;
      r_frame_sync   <= 1'b0;
      r_rd_bank      <= 1'b1;
      r_pixel_out    <= '0;
    end else begin
      r_count_h_prev <= count_h;
      r_count_v_prev <= count_v;
      r_line_sync    <= w_line_evt;
      r_frame_sync   <= w_frame_evt;
      r_pixel_out    <= w_pix_nxt;
      // A new frame parks reads on bank 1 so line 0 never shows the other bank's stale line.
      if (w_frame_evt) begin
        r_rd_bank <= 1'b1;
      end else if (w_line_evt) begin
        r_rd_bank <= count_v[0];
      end else begin
        r_rd_bank <= r_rd_bank;
      end
    end
  end

  assign pixel_out  = r_pixel_out;
  assign line_sync  = r_line_sync;
  assign frame_sync = r_frame_sync;

endmodule

// File: tb/tb_nes_line_doubler.sv
// Directed self-checking bench for nes_line_doubler (default build and LINE_DOUBLER_BLEND_EN).
module tb_nes_line_doubler;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] pixel_in;
  logic [8:0]  count_h;
  logic [8:0]  count_v;
  logic [9:0]  rd_x;
  logic [14:0] pixel_out;
  logic        frame_sync;
  logic        line_sync;

  int total = 0;
  int bad   = 0;
  int ls_cnt = 0;
  int fs_cnt = 0;
  int ls0;
  int fs0;

  always #5 clk = ~clk;

  nes_line_doubler #(.PIX_W(15), .FIRST_LINE_SYNC_H(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .pixel_in  (pixel_in),
    .count_h   (count_h),
    .count_v   (count_v),
    .rd_x      (rd_x),
    .pixel_out (pixel_out),
    .frame_sync(frame_sync),
    .line_sync (line_sync)
  );

  // Pulses are one clk wide, so sampling on the falling edge counts each exactly once.
  always @(negedge clk) begin
    if (line_sync === 1'b1) ls_cnt++;
    if (frame_sync === 1'b1) fs_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] pix_for(input int mode, input logic [14:0] cval, input int h);
    case (mode)
      0: return cval;
      1: return 15'(h);
      2: return 15'h4000 | 15'(h);
      3: begin
        if (h == 4) return 15'h0000;
        else if (h == 5) return 15'h7FFF;
        else if (h == 255) return 15'h1234;
        else return 15'(h);
      end
      default: return 15'h0000;
    endcase
  endfunction

  function automatic logic [14:0] avg2(input logic [14:0] a, input logic [14:0] b);
    int r, g, bl;
    r  = (int'(a[4:0])   + int'(b[4:0]))   / 2;
    g  = (int'(a[9:5])   + int'(b[9:5]))   / 2;
    bl = (int'(a[14:10]) + int'(b[14:10])) / 2;
    return {bl[4:0], g[4:0], r[4:0]};
  endfunction

  // Expected output for column 2n (odd=0) or 2n+1 (odd=1) given P[n] and P[n+1].
  function automatic logic [14:0] exp_pair(input logic [14:0] pn, input logic [14:0] pn1, input bit odd);
`ifdef LINE_DOUBLER_BLEND_EN
    if (odd) return avg2(pn, pn1);
    else return pn;
`else
    return pn;
`endif
  endfunction

  task automatic drive_line(input int v, input int h0, input int h1, input int mode, input logic [14:0] cval);
    for (int h = h0; h <= h1; h++) begin
      count_v  = 9'(v);
      count_h  = 9'(h);
      pixel_in = pix_for(mode, cval, h);
      repeat (4) tick();
    end
  endtask

  task automatic idle(input int n);
    count_h = 9'd340;
    count_v = 9'd300;
    repeat (n) tick();
  endtask

  task automatic rd_chk(input string tag, input int x, input logic [14:0] exp);
    rd_x = 10'(x);
    tick();
    chk(tag, {17'd0, pixel_out}, {17'd0, exp});
  endtask

  initial begin
    logic [14:0] pn;
    logic [14:0] pn1;
    reset    = 1'b1;
    pixel_in = 15'd0;
    count_h  = 9'd0;
    count_v  = 9'd0;
    rd_x     = 10'd600;
    repeat (3) tick();
    chk("reset_pixel_out", {17'd0, pixel_out}, 32'd0);
    chk("reset_frame_sync", {31'd0, frame_sync}, 32'd0);
    chk("reset_line_sync", {31'd0, line_sync}, 32'd0);
    reset = 1'b0;
    idle(4);

    // Line 10 ramp with an exact line_sync timing check at dot 256.
    ls0 = ls_cnt;
    drive_line(10, 0, 255, 1, 15'd0);
    count_h  = 9'd256;
    pixel_in = 15'd0;
    tick();
    chk("line_sync_rise", {31'd0, line_sync}, 32'd1);
    tick();
    chk("line_sync_fall", {31'd0, line_sync}, 32'd0);
    tick();
    tick();
    drive_line(10, 257, 340, 1, 15'd0);
    chk("line_sync_count_l10", 32'(ls_cnt - ls0), 32'd1);
    for (int k = 0; k < 512; k++) begin
      pn  = 15'(k / 2);
      pn1 = ((k / 2) == 255) ? pn : 15'((k / 2) + 1);
      rd_chk("ramp_readback", k, exp_pair(pn, pn1, (k % 2) == 1));
    end
    rd_chk("rd_x_600_black", 600, 15'h0000);
    rd_chk("rd_x_512_black", 512, 15'h0000);

    // Ping-pong between banks.
    drive_line(12, 0, 340, 0, 15'h001F);
    rd_chk("pp_l12_x0", 0, 15'h001F);
    rd_chk("pp_l12_x511", 511, 15'h001F);
    drive_line(13, 0, 200, 0, 15'h7C00);
    rd_chk("pp_during_l13_x0", 0, 15'h001F);
    rd_chk("pp_during_l13_x301", 301, 15'h001F);
    drive_line(13, 201, 340, 0, 15'h7C00);
    rd_chk("pp_l13_x0", 0, 15'h7C00);
    rd_chk("pp_l13_x255", 255, 15'h7C00);
    rd_chk("pp_l13_x511", 511, 15'h7C00);

    // Frame boundary: no sync or write on line 240, read bank forced to 1 after frame_sync.
    drive_line(238, 0, 340, 0, 15'h0055);
    rd_chk("l238_x6", 6, 15'h0055);
    ls0 = ls_cnt;
    drive_line(240, 0, 340, 0, 15'h0777);
    chk("no_line_sync_v240", 32'(ls_cnt - ls0), 32'd0);
    rd_chk("no_write_v240", 6, 15'h0055);
    drive_line(511, 0, 340, 0, 15'h0000);
    fs0 = fs_cnt;
    count_v = 9'd0;
    count_h = 9'd0;
    tick();
    chk("frame_sync_rise", {31'd0, frame_sync}, 32'd1);
    tick();
    chk("frame_sync_fall", {31'd0, frame_sync}, 32'd0);
    repeat (4) tick();
    chk("frame_sync_count", 32'(fs_cnt - fs0), 32'd1);
    rd_chk("frame_reads_bank1", 6, 15'h7C00);

    // Reset in the middle of line 20.
    idle(2);
    drive_line(20, 0, 99, 0, 15'h0111);
    rd_chk("pre_reset_x3", 3, 15'h7C00);
    count_h = 9'd100;
    reset   = 1'b1;
    tick();
    chk("midreset_pixel_out", {17'd0, pixel_out}, 32'd0);
    chk("midreset_line_sync", {31'd0, line_sync}, 32'd0);
    chk("midreset_frame_sync", {31'd0, frame_sync}, 32'd0);
    reset = 1'b0;
    idle(2);
    drive_line(21, 0, 340, 2, 15'd0);
    rd_chk("l21_x0", 0, 15'h4000);
    rd_chk("l21_x300", 300, 15'h4000 | 15'd150);
    rd_chk("l21_x510", 510, 15'h4000 | 15'd255);
    rd_chk("l21_x511", 511, 15'h4000 | 15'd255);

    // count_h stalled at 50: only the first clk of the dot is written.
    drive_line(22, 0, 49, 1, 15'd0);
    count_h  = 9'd50;
    pixel_in = 15'h0AAA;
    tick();
    pixel_in = 15'h0BBB;
    repeat (11) tick();
    drive_line(22, 51, 340, 1, 15'd0);
    rd_chk("stall_x98", 98, 15'd49);
    rd_chk("stall_x100", 100, 15'h0AAA);
    rd_chk("stall_x101", 101, exp_pair(15'h0AAA, 15'd51, 1'b1));
    rd_chk("stall_x102", 102, 15'd51);

    // Neighbour pattern for blending.
    drive_line(24, 0, 340, 3, 15'd0);
    rd_chk("blend_x8", 8, 15'h0000);
    rd_chk("blend_x10", 10, 15'h7FFF);
`ifdef LINE_DOUBLER_BLEND_EN
    rd_chk("blend_x9", 9, 15'h3DEF);
    rd_chk("blend_x11", 11, 15'h3DF2);
`else
    rd_chk("blend_x9", 9, 15'h0000);
    rd_chk("blend_x11", 11, 15'h7FFF);
`endif
    rd_chk("blend_x510", 510, 15'h1234);
    rd_chk("blend_x511", 511, 15'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
